// File: rtl/restoring_div_nbit.sv
// restoring_div_nbit: sequential unsigned restoring divider, one quotient bit per clock
// start/busy/done handshake; divide-by-zero completes immediately with all-ones quotient
module restoring_div_nbit #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nx;
   logic [N-1:0] r, q, d, nr, nq;
   logic [N:0] t;
   logic [CW-1:0] cnt;
   logic accept, last;
   always_comb begin
      accept = start && state != RUN;
      last = cnt == '0;
      t = {r, q[N-1]} - {1'b0, d};
      nr = t[N] ? {r[N-2:0], q[N-1]} : t[N-1:0];
      nq = {q[N-2:0], ~t[N]};
      state_nx = accept ? (divisor == '0 ? FIN : RUN) : IDLE;
      if (state == RUN)
         state_nx = last ? FIN : RUN;
      busy = state == RUN;
      done = state == FIN;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   // the partial remainder always stays below the divisor, so N bits hold it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r <= '0;
         q <= '0;
         d <= '0;
         cnt <= '0;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (divisor == '0) begin
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            r <= '0;
            q <= dividend;
            d <= divisor;
            cnt <= CW'(N - 1);
         end
      end else if (state == RUN) begin
         r <= nr;
         q <= nq;
         cnt <= cnt - CW'(1);
         if (last) begin
            quotient <= nq;
            remainder <= nr;
            div_by_zero <= 1'b0;
         end
      end
endmodule

// File: tb/tb_restoring_div_nbit.sv
// tb_restoring_div_nbit: vector table, corner sequences and exhaustive sweep,
// results checked through a scoreboard queue popped on each done pulse
module tb_restoring_div_nbit;
   localparam int N = 4;
   typedef struct {
      logic [N-1:0] a, b, q, r;
      logic z;
   } vec_t;
   typedef struct {
      logic [N-1:0] q, r;
      logic z;
   } res_t;
   logic clk = 0, rst_n = 0, start = 0;
   logic [N-1:0] dividend = 0, divisor = 0;
   logic busy, done, div_by_zero;
   logic [N-1:0] quotient, remainder;
   int tests = 0, fails = 0;
   res_t sb[$];
   vec_t tbl[8];

   restoring_div_nbit #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (rst_n && done) begin
         if (sb.size() == 0)
            check("unexpected_done", 1, 0);
         else begin
            res_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.z);
         end
      end

   task automatic push(input logic [N-1:0] q, r, input logic z);
      res_t e;
      e.q = q; e.r = r; e.z = z;
      sb.push_back(e);
   endtask

   // called #1 after an edge with start low; walks edges until done appears
   task automatic wait_done(input int exp_lat, input int exp_busy);
      int k = 0, nb = 0;
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++)
         if (done)
            seen = 1;
         else begin
            if (busy) nb++;
            @(posedge clk); #1;
            k++;
         end
      check("done_timeout", seen, 1);
      check("latency", k, exp_lat);
      check("busy_cycles", nb, exp_busy);
   endtask

   task automatic run_op(input logic [N-1:0] a, b, q, r, input logic z);
      @(negedge clk);
      start = 1; dividend = a; divisor = b;
      push(q, r, z);
      @(posedge clk); #1;
      start = 0; dividend = N'($urandom); divisor = N'($urandom);
      wait_done(b == 0 ? 0 : N, b == 0 ? 0 : N);
   endtask

   initial begin
      tbl[0] = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0};
      tbl[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
      tbl[2] = '{4'd5, 4'd7, 4'd0, 4'd5, 1'b0};
      tbl[3] = '{4'd9, 4'd0, 4'd15, 4'd9, 1'b1};
      tbl[4] = '{4'd8, 4'd2, 4'd4, 4'd0, 1'b0};
      tbl[5] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b0};
      tbl[6] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
      tbl[7] = '{4'd0, 4'd0, 4'd15, 4'd0, 1'b1};
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_z", div_by_zero, 0);
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 8; i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);
      // start during RUN is ignored; then back-to-back start from the done cycle
      @(negedge clk);
      start = 1; dividend = 14; divisor = 4;
      push(3, 2, 0);
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1;
      check("busy_mid", busy, 1);
      @(negedge clk);
      start = 1; dividend = 7; divisor = 7;
      @(posedge clk); #1 start = 0;
      wait_done(N - 2, N - 2);
      start = 1; dividend = 12; divisor = 5;
      push(2, 2, 0);
      @(posedge clk); #1 start = 0;
      wait_done(N, N);
      // abort mid-operation with asynchronous reset
      @(negedge clk);
      start = 1; dividend = 11; divisor = 2;
      @(posedge clk); #1 start = 0;
      @(posedge clk);
      @(posedge clk); #2 rst_n = 0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_q", quotient, 0);
      check("abort_r", remainder, 0);
      check("abort_z", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (8) @(posedge clk);
      #1 check("idle_after_abort", busy, 0);
      run_op(11, 2, 5, 1, 0);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            if (b == 0)
               run_op(N'(a), 0, '1, N'(a), 1);
            else
               run_op(N'(a), N'(b), N'(a / b), N'(a % b), 0);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
